// File: rtl/uart_rx_byte_capture.sv
// 8N1 serial receiver: synchronises rxd, samples each bit at its centre and
// holds the last good byte with valid/overrun/frame-error status for software.
module uart_rx_byte_capture #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic             r_s1;
    logic             r_s2;
    logic             w_sample_bit;
    logic             w_load;
    logic             w_ferr;

    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;

    // Input synchroniser: idle-high line, so both flops reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= rxd;
            r_s2 <= r_s1;
        end
    end

    // Frame FSM state and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_bit_nxt    = r_bit;
        w_sample_bit = 1'b0;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_s2) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // A line that is high again at the start-bit centre was a glitch.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt    = '0;
                    w_sample_bit = 1'b1;
                    w_bit_nxt    = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_s2) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // Hold off through a break so it reports only one frame error.
                w_cnt_nxt = '0;
                if (r_s2) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Every bit is rewritten before a load, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_sample_bit) begin
            r_shift[r_bit] <= r_s2;
        end
    end

    // Software-facing byte and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx_data <= r_shift;
            end

            if (w_load) begin
                r_rx_valid <= 1'b1;
            end else if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end

            if (w_ferr) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end

            // An ack landing with the new byte means the old one was read.
            if (w_load && r_rx_valid && !rx_ack) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte_capture.sv
// Self-checking bench for uart_rx_byte_capture with 16 clocks per bit.
module tb_uart_rx_byte_capture;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rx_ack;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    uart_rx_byte_capture #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT    (CPB / 2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_ack   (rx_ack),
        .err_clr  (err_clr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    // Caller must be at a falling clock edge; returns at one, after the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit good);
        if (good) exp_q.push_back(b);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk) rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rxd     = 1'b1;
        rx_ack  = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int cyc;
        cyc = 0;
        fork
            send_byte(8'hA5, 1'b1, 1'b1);
            begin
                while (rx_valid !== 1'b1 && cyc < 400) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
            end
        join
        checks++; if (cyc != 155) begin errors++; $display("FAIL single_latency: got %0d cycles want 155", cyc); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL single_data: got %h want scoreboard entry (queue empty)", rx_data);
        end else begin
            exp_b = exp_q.pop_front();
            if (rx_data !== exp_b) begin errors++; $display("FAIL single_data: got %h want %h", rx_data, exp_b); end
        end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_ovr: got %b want 0", overrun); end
        pulse_ack();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ack_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ack_data: got %h want a5", rx_data); end
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b want 0", frame_err); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h want a5", rx_data); end
    endtask

    task automatic test_frame_error();
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b want 1", frame_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b want 1", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL break_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL break_data: got %h want a5", rx_data); end
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release: got %b want 0", busy); end
        send_byte(8'h81, 1'b1, 1'b1);
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL after_break_data: got %h want scoreboard entry (queue empty)", rx_data);
        end else begin
            exp_b = exp_q.pop_front();
            if (rx_data !== exp_b) begin errors++; $display("FAIL after_break_data: got %h want %h", rx_data, exp_b); end
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL after_break_valid: got %b want 1", rx_valid); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
        pulse_err_clr();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL err_clr_ferr: got %b want 0", frame_err); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL err_clr_valid: got %b want 1", rx_valid); end
    endtask

    task automatic test_back_to_back();
        pulse_ack();
        send_byte(8'h11, 1'b1, 1'b1);
        send_byte(8'h22, 1'b1, 1'b1);
        // 0x11 is overwritten by 0x22 before being read.
        if (exp_q.size() != 0) exp_b = exp_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_data: got %h want scoreboard entry (queue empty)", rx_data);
        end else begin
            exp_b = exp_q.pop_front();
            if (rx_data !== exp_b) begin errors++; $display("FAIL b2b_data: got %h want %h", rx_data, exp_b); end
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    endtask

    task automatic test_ack_collision();
        pulse_err_clr();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL err_clr_ovr: got %b want 0", overrun); end
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL err_clr_data: got %h want 22", rx_data); end
        fork
            send_byte(8'h55, 1'b1, 1'b1);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk) rx_ack = 1'b1;
                @(negedge clk) rx_ack = 1'b0;
            end
        join
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL collide_data: got %h want scoreboard entry (queue empty)", rx_data);
        end else begin
            exp_b = exp_q.pop_front();
            if (rx_data !== exp_b) begin errors++; $display("FAIL collide_data: got %h want %h", rx_data, exp_b); end
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL collide_valid: got %b want 1", rx_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL collide_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_reset_midframe();
        fork
            send_byte(8'hF0, 1'b1, 1'b0);
            begin
                repeat (CPB * 5 + 8) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h want 00", rx_data); end
        send_byte(8'h0F, 1'b1, 1'b1);
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL post_reset_data: got %h want scoreboard entry (queue empty)", rx_data);
        end else begin
            exp_b = exp_q.pop_front();
            if (rx_data !== exp_b) begin errors++; $display("FAIL post_reset_data: got %h want %h", rx_data, exp_b); end
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: got %b want 1", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL post_reset_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL post_reset_ovr: got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_ack_collision();
        test_reset_midframe();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_byte_capture.md
Name: uart_rx_byte_capture

Overview:
- Serial receiver upstream of the 8-bit PIO input port. Deserialises 8N1 asynchronous frames from the external `rxd` pin.
- Holds each received byte stable on `rx_data`, which is wired to the PIO's 8-bit input. Status flags go to a second status PIO.
- Software acknowledges each byte through a one-cycle `rx_ack` pulse from an output PIO.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per bit (50 MHz / 9600 baud). Must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2: cycles from the detected start edge to the start-bit centre.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rxd  in  1  raw serial line, idle high, asynchronous to clk.
- rx_ack  in  1  one-cycle pulse; software has read rx_data.
- err_clr  in  1  one-cycle pulse; clears frame_err and overrun.
- rx_data  out  8  last good byte received; held until the next good byte.
- rx_valid  out  1  unread byte present in rx_data.
- frame_err  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a good byte landed while rx_valid was still set.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, active-high):
  - 2-FF synchroniser flops go to 1.
  - FSM goes to IDLE; bit counter and cycle counter go to 0.
  - rx_data = 0x00; rx_valid, frame_err, overrun and busy all go to 0.
- Synchroniser: rxd → s1 → s2. All decisions use s2, so there are 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. busy = (state != IDLE).
  - IDLE: s2 == 0 → START, cycle counter cleared.
  - START: counts to HALF_BIT−1, then samples s2.
    - s2 == 0: go to DATA with bit index 0 and counter cleared.
    - s2 == 1: glitch; return to IDLE, no flags set.
  - DATA: every CLKS_PER_BIT cycles, sample s2 into shift[bit index]. Bits arrive LSB first.
    - After bit index 7 is sampled → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample s2.
    - s2 == 1: load rx_data and set rx_valid on the next edge, then → IDLE.
    - s2 == 0: set frame_err, leave rx_data and rx_valid unchanged, then → WAIT_IDLE.
  - WAIT_IDLE: stay until s2 == 1, then → IDLE. A break condition therefore produces exactly one frame_err.
- Latency: rx_valid rises 1 cycle after the stop-bit sample point. The stop-bit sample point is HALF_BIT + 9×CLKS_PER_BIT cycles after s2 first goes low.
- Handshake:
  - rx_valid set on a good load; cleared on rx_ack.
  - rx_ack while rx_valid = 0: no effect.
  - Load and rx_ack in the same cycle: load wins; rx_valid stays 1, no overrun.
- Overrun: a good load while rx_valid = 1 and rx_ack = 0 sets overrun. The new byte overwrites rx_data; the older byte is lost.
- err_clr clears frame_err and overrun.
  - If err_clr coincides with a new error event, the set wins.
  - err_clr does not affect rx_valid or rx_data.
- Back-to-back frames: a start edge seen in the cycle IDLE is entered is accepted. There is no dead time beyond the single IDLE cycle.
- Reset mid-frame: the partial byte is discarded; the next frame is received only after the line is seen low again from IDLE.

Test Plan (CLKS_PER_BIT = 16):
- Send 0xA5 as 8N1 → rx_data = 0xA5 and rx_valid = 1 exactly 1 + 2 + 8 + 144 cycles after the rxd falling edge; frame_err = 0, overrun = 0. Pulse rx_ack → rx_valid = 0, rx_data stays 0xA5.
- rxd low for 5 cycles, then high → FSM returns to IDLE; rx_valid, frame_err and rx_data unchanged.
- Send 0x3C with the stop bit forced low, line held low for 40 cycles, then send 0x81 correctly → frame_err = 1, rx_data = 0x81, rx_valid = 1. Pulse err_clr → frame_err = 0.
- Send 0x11 then 0x22 back to back with no ack → rx_data = 0x22, rx_valid = 1, overrun = 1.
- Send 0x55 with rx_ack pulsed in the same cycle rx_valid would rise from a prior byte → rx_valid = 1, overrun = 0.
- Assert reset during data bit 4 of 0xF0, release, then send 0x0F → rx_data = 0x0F; no stale bits from 0xF0; no flags set.
